hazard_sequencer: RTL and testbench

Central hazard and stall controller for the 5-stage pipelined CPU. It drives forwarding selects into Execute and stall/flush controls for the F/D, D/E, E/M and M/W pipeline registers, including the M-to-W register. It also runs the data-memory request/ready handshake for multi-cycle memory accesses and keeps saturating performance counters.

---
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Hazard/stall controller for the 5-stage pipeline: operand forwarding, load-use and
// memory-wait stalls, branch flushes, data-memory handshake and saturating event counters.
module hazard_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       RA1D,
    input  logic [4:0]       RA2D,
    input  logic [4:0]       RA1E,
    input  logic [4:0]       RA2E,
    input  logic [4:0]       WA3E,
    input  logic [4:0]       WA3M,
    input  logic [4:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemReqM,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall, mem_req, ldr_stall, pc_wr_pending;

    function automatic logic [1:0] fwd_sel(input logic [4:0] ra, input logic [4:0] wa_m,
                                           input logic we_m, input logic [4:0] wa_w,
                                           input logic we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (ZERO_REG_EN && ra == 5'd0)
            sel = 2'b00;
        else if (we_m && wa_m == ra)
            sel = 2'b10;
        else if (we_w && wa_w == ra)
            sel = 2'b01;
        return sel;
    endfunction

    assign ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
    assign ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);

    assign ldr_stall = MemToRegE && ((WA3E == RA1D) || (WA3E == RA2D))
                       && !(ZERO_REG_EN && WA3E == 5'd0);
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        mem_err_d = mem_err_q;
        mem_stall = 1'b0;
        mem_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_req = MemAccessM;
                if (MemAccessM && !MemReadyM) begin
                    mem_stall = 1'b1;
                    state_d   = S_WAIT;
                    tcnt_d    = TW'(1);
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                if (MemReadyM) begin
                    state_d = S_IDLE;
                    tcnt_d  = '0;
                end else if (tcnt_q == TMAX) begin
                    // Abandon the access; the W bubble already inserted is kept.
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                    tcnt_d    = '0;
                end else begin
                    mem_stall = 1'b1;
                    tcnt_d    = tcnt_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    // Gating with RST_N makes every control drop the instant reset asserts.
    assign StallM  = RST_N & mem_stall;
    assign StallE  = RST_N & mem_stall;
    assign StallD  = RST_N & (mem_stall | ldr_stall);
    assign StallF  = RST_N & (mem_stall | ldr_stall | pc_wr_pending);
    assign FlushW  = RST_N & mem_stall;
    assign FlushD  = RST_N & !mem_stall & (pc_wr_pending | PCSrcW | BranchTakenE);
    assign FlushE  = RST_N & !mem_stall & (ldr_stall | BranchTakenE);
    assign MemReqM = RST_N & mem_req;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((FlushD || FlushE) && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            tcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemErr     = mem_err_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed plus randomized bench for hazard_sequencer against a behavioural model that
// tracks how long the current memory access has been outstanding.
module tb_hazard_sequencer;
    localparam int CNT_W = 5;
    localparam int T     = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic CLK, RST_N;
    logic [4:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteM, RegWriteW, MemToRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic BranchTakenE, MemAccessM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReqM, MemErr;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(T), .ZERO_REG_EN(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemReqM(MemReqM), .MemErr(MemErr),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    // Model state: cycles the current access has already stalled (0 = none outstanding).
    int waited = 0;
    bit err_m = 0;
    int scnt_m = 0;
    int fcnt_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_m(input logic [4:0] ra);
        if (ra == 0) return 2'b00;
        if (RegWriteM && WA3M == ra) return 2'b10;
        if (RegWriteW && WA3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_in();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemToRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
        {BranchTakenE, MemAccessM, MemReadyM} = '0;
    endtask

    // Checks all outputs for the currently driven inputs, then advances one clock.
    task automatic cycle();
        bit ms, ldr, pcw, fd, fe, sf;
        #1;
        ldr = MemToRegE && WA3E != 0 && (WA3E == RA1D || WA3E == RA2D);
        pcw = PCSrcD || PCSrcE || PCSrcM;
        ms  = !MemReadyM && (waited > 0 || MemAccessM) && waited < T;
        sf  = ms || ldr || pcw;
        fd  = !ms && (pcw || PCSrcW || BranchTakenE);
        fe  = !ms && (ldr || BranchTakenE);
        chk("ForwardAE", ForwardAE, fwd_m(RA1E));
        chk("ForwardBE", ForwardBE, fwd_m(RA2E));
        chk("StallF", StallF, sf);
        chk("StallD", StallD, ms || ldr);
        chk("StallE", StallE, ms);
        chk("StallM", StallM, ms);
        chk("FlushW", FlushW, ms);
        chk("FlushD", FlushD, fd);
        chk("FlushE", FlushE, fe);
        chk("MemReqM", MemReqM, waited > 0 || MemAccessM);
        if (ms) waited++;
        else begin
            if (waited > 0 && !MemReadyM) err_m = 1;
            waited = 0;
        end
        if (sf && scnt_m < CMAX) scnt_m++;
        if ((fd || fe) && fcnt_m < CMAX) fcnt_m++;
        @(posedge CLK);
        #1;
        chk("StallCount", StallCount, scnt_m);
        chk("FlushCount", FlushCount, fcnt_m);
        chk("MemErr", MemErr, err_m);
    endtask

    initial begin
        int prev;
        clear_in();
        RST_N = 1'b0;
        PCSrcD = 1'b1; BranchTakenE = 1'b1; MemAccessM = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        $display("[TB] reset state");
        chk("rst_StallF", StallF, 0);
        chk("rst_FlushD", FlushD, 0);
        chk("rst_MemReqM", MemReqM, 0);
        chk("rst_StallCount", StallCount, 0);
        chk("rst_MemErr", MemErr, 0);
        clear_in();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] RAW forwarding");
        WA3M = 5; RegWriteM = 1; WA3W = 5; RegWriteW = 1; RA1E = 5; RA2E = 3;
        #1 chk("fwd_M", ForwardAE, 2'b10);
        cycle();
        RegWriteM = 0;
        #1 chk("fwd_W", ForwardAE, 2'b01);
        cycle();
        RA1E = 0; WA3W = 0;
        #1 chk("fwd_zero", ForwardAE, 2'b00);
        cycle();
        clear_in();

        $display("[TB] load-use stall");
        MemToRegE = 1; WA3E = 7; RA2D = 7;
        prev = scnt_m;
        #1;
        chk("lu_StallF", StallF, 1);
        chk("lu_StallD", StallD, 1);
        chk("lu_FlushE", FlushE, 1);
        chk("lu_StallE", StallE, 0);
        cycle();
        chk("lu_StallCount", StallCount, prev + 1);
        MemToRegE = 0;
        #1 chk("lu_once", StallF, 0);
        cycle();

        $display("[TB] multi-cycle memory with branch held");
        MemAccessM = 1; MemReadyM = 0; BranchTakenE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mc_StallM", StallM, 1);
            chk("mc_FlushW", FlushW, 1);
            chk("mc_MemReqM", MemReqM, 1);
            chk("mc_FlushD_held", FlushD, 0);
            cycle();
        end
        MemReadyM = 1;
        #1;
        chk("mc_rdy_StallF", StallF, 0);
        chk("mc_rdy_MemReqM", MemReqM, 1);
        chk("br_rel_FlushD", FlushD, 1);
        chk("br_rel_FlushE", FlushE, 1);
        cycle();
        clear_in();
        #1 chk("mc_idle", MemReqM, 0);
        cycle();

        $display("[TB] timeout");
        MemAccessM = 1; MemReadyM = 0;
        for (int i = 0; i < T; i++) begin
            #1 chk("to_stall", StallM, 1);
            cycle();
        end
        #1 chk("to_release", StallM, 0);
        cycle();
        chk("to_MemErr", MemErr, 1);
        MemAccessM = 0;
        cycle();
        cycle();
        chk("to_sticky", MemErr, 1);

        $display("[TB] async reset mid-WAIT");
        MemAccessM = 1; MemReadyM = 0;
        cycle();
        cycle();
        #2 RST_N = 1'b0;
        #1;
        chk("ar_MemReqM", MemReqM, 0);
        chk("ar_StallF", StallF, 0);
        chk("ar_FlushW", FlushW, 0);
        chk("ar_StallCount", StallCount, 0);
        chk("ar_FlushCount", FlushCount, 0);
        chk("ar_MemErr", MemErr, 0);
        waited = 0; err_m = 0; scnt_m = 0; fcnt_m = 0;
        clear_in();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        cycle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            RA1D = 5'($urandom_range(0, 3)); RA2D = 5'($urandom_range(0, 3));
            RA1E = 5'($urandom_range(0, 3)); RA2E = 5'($urandom_range(0, 3));
            WA3E = 5'($urandom_range(0, 3)); WA3M = 5'($urandom_range(0, 3));
            WA3W = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            MemToRegE = ($urandom_range(0, 3) == 0);
            PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
            PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            MemAccessM = 1'($urandom_range(0, 1));
            MemReadyM = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("[TB] counter saturation");
        clear_in();
        PCSrcD = 1;
        for (int n = 0; n < CMAX + 4; n++) cycle();
        chk("sat_StallCount", StallCount, CMAX);
        chk("sat_FlushCount", FlushCount, CMAX);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
